pipe_recovery_ctrl: RTL and testbench

PIPE_RECOVERY_CTRL -- requirements
Module: pipe_recovery_ctrl

---
 rtl/pipe_recovery_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_recovery_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_recovery_ctrl.sv
// Pipeline recovery controller: sequences PC redirect, IF/ID and ID/EX flushes
// across fetch back-pressure, and keeps saturating branch/mispredict counters.
module pipe_recovery_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mispre,
  input  logic [1:0]       i_pc_src,
  input  logic             i_branch_E,
  input  logic             i_load_use,
  input  logic             i_imem_ready,
  output logic             o_pc_we,
  output logic             o_stall_D,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic [1:0]       o_pc_src,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispre_cnt
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_WAIT_FETCH = 2'd1;
  localparam logic [1:0] ST_MASK       = 2'd2;
  localparam logic [1:0] SRC_PC4       = 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [1:0]       src_q, src_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispre_cnt_q, mispre_cnt_d;
  logic             pc_we_s, stall_d_s, flush_d_s, flush_e_s;
  logic [1:0]       pc_src_s;
  logic             in_run_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign in_run_s = (state_q == ST_RUN);

  // Next-state and combinational pipeline-control decode
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    pc_we_s   = 1'b0;
    stall_d_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    pc_src_s  = i_pc_src;
    if (i_rst) begin
      pc_src_s = SRC_PC4;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (i_mispre) begin
            // Redirect wins over load-use; the chosen source is kept for retries.
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
            pc_we_s   = i_imem_ready;
            src_d     = i_pc_src;
            state_d   = i_imem_ready ? ST_MASK : ST_WAIT_FETCH;
          end else begin
            pc_we_s   = i_imem_ready & ~i_load_use;
            stall_d_s = i_load_use;
            flush_e_s = i_load_use;
          end
        end
        ST_WAIT_FETCH: begin
          pc_src_s  = src_q;
          flush_d_s = 1'b1;
          flush_e_s = 1'b1;
          pc_we_s   = i_imem_ready;
          state_d   = i_imem_ready ? ST_MASK : ST_WAIT_FETCH;
        end
        ST_MASK: begin
          // E holds a bubble here, so mispredict and branch resolution are ignored.
          pc_we_s   = i_imem_ready & ~i_load_use;
          stall_d_s = i_load_use;
          flush_e_s = i_load_use;
          state_d   = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating performance counters, only live while in RUN
  always_comb begin
    branch_cnt_d = sat_inc(branch_cnt_q, in_run_s & i_branch_E);
    mispre_cnt_d = sat_inc(mispre_cnt_q, in_run_s & i_branch_E & i_mispre);
  end

  // State, latched redirect source and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      src_q        <= SRC_PC4;
      branch_cnt_q <= {CNT_W{1'b0}};
      mispre_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      branch_cnt_q <= branch_cnt_d;
      mispre_cnt_q <= mispre_cnt_d;
    end
  end

  assign o_pc_we      = pc_we_s;
  assign o_stall_D    = stall_d_s;
  assign o_flush_D    = flush_d_s;
  assign o_flush_E    = flush_e_s;
  assign o_pc_src     = pc_src_s;
  assign o_state      = state_q;
  assign o_branch_cnt = branch_cnt_q;
  assign o_mispre_cnt = mispre_cnt_q;

endmodule

// File: tb/tb_pipe_recovery_ctrl.sv
// Randomized + directed bench for pipe_recovery_ctrl against a behavioural model.
module tb_pipe_recovery_ctrl;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst, mis, br, lu, rdy;
  logic [1:0]    src;
  logic          pc_we, stall_D, flush_D, flush_E;
  logic [1:0]    pc_src_o, state_o;
  logic [CW-1:0] bcnt, mcnt;

  int n_vec = 0;
  int n_err = 0;
  // Model: mode 0 = running, 1 = waiting for fetch to accept, 2 = masked cycle
  int m_mode = 0, m_src = 1, m_bc = 0, m_mc = 0;

  pipe_recovery_ctrl #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_mispre(mis), .i_pc_src(src), .i_branch_E(br),
    .i_load_use(lu), .i_imem_ready(rdy), .o_pc_we(pc_we), .o_stall_D(stall_D),
    .o_flush_D(flush_D), .o_flush_E(flush_E), .o_pc_src(pc_src_o), .o_state(state_o),
    .o_branch_cnt(bcnt), .o_mispre_cnt(mcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic m, input logic [1:0] s,
                       input logic b, input logic l, input logic y);
    int e_we, e_st, e_fd, e_fe, e_src;
    @(negedge clk);
    rst = r; mis = m; src = s; br = b; lu = l; rdy = y;
    #1;
    e_we = 0; e_st = 0; e_fd = 0; e_fe = 0; e_src = s;
    if (r) begin
      e_src = 1;
    end else if (m_mode == 1) begin
      e_src = m_src; e_fd = 1; e_fe = 1; e_we = y;
    end else if (m_mode == 0 && m) begin
      e_fd = 1; e_fe = 1; e_we = y;
    end else begin
      e_we = y & ~l; e_st = l; e_fe = l;
    end
    n_vec++;
    chk("state", state_o, m_mode);
    chk("branch_cnt", bcnt, m_bc);
    chk("mispre_cnt", mcnt, m_mc);
    chk("pc_we", pc_we, e_we);
    chk("stall_D", stall_D, e_st);
    chk("flush_D", flush_D, e_fd);
    chk("flush_E", flush_E, e_fe);
    chk("pc_src", pc_src_o, e_src);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_src = 1; m_bc = 0; m_mc = 0;
    end else if (m_mode == 0) begin
      if (br) m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      if (br && mis) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
      if (mis) begin
        m_src  = src;
        m_mode = rdy ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      m_mode = rdy ? 2 : 1;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
  endtask

  int b0, m0;

  initial begin
    rst = 1'b1; mis = 1'b0; src = 2'd1; br = 1'b0; lu = 1'b0; rdy = 1'b1;
    apply(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1); tick();
    chk("rst_pc_src", pc_src_o, 1); chk("rst_flush_D", flush_D, 0);
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1); tick();
    idle();
    chk("rst_state", state_o, 0); chk("rst_bcnt", bcnt, 0); chk("rst_mcnt", mcnt, 0);
    tick();

    // Branch mispredict, fetch ready
    apply(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    chk("mp_flush_D", flush_D, 1); chk("mp_flush_E", flush_E, 1);
    chk("mp_pc_we", pc_we, 1); chk("mp_pc_src", pc_src_o, 2);
    tick();
    idle(); chk("mp_mask", state_o, 2); tick();
    idle(); chk("mp_run", state_o, 0); chk("mp_mcnt", mcnt, 1); tick();

    // Mispredict stalled by fetch for 3 cycles
    apply(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("wf_first_we", pc_we, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'(i != 1), 2'd0, 1'(i == 0), 1'(i == 2), 1'b0);
      chk("wf_state", state_o, 1); chk("wf_pc_src", pc_src_o, 3);
      chk("wf_flush_D", flush_D, 1); chk("wf_flush_E", flush_E, 1); chk("wf_we", pc_we, 0);
      tick();
    end
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("wf_release_we", pc_we, 1); chk("wf_release_src", pc_src_o, 3); tick();
    idle(); chk("wf_mask", state_o, 2); tick();
    idle(); chk("wf_run", state_o, 0); chk("wf_mcnt", mcnt, 1); tick();

    // Mispredict beats load-use
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("pri_stall", stall_D, 0); chk("pri_flush_D", flush_D, 1); chk("pri_we", pc_we, 1);
    tick();
    idle(); tick();

    // Mispredict + branch inside MASK is ignored
    apply(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1); tick();
    b0 = bcnt; m0 = mcnt;
    apply(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    chk("mask_state", state_o, 2); chk("mask_flush_D", flush_D, 0); chk("mask_flush_E", flush_E, 0);
    tick();
    idle();
    chk("mask_exit", state_o, 0); chk("mask_bcnt", bcnt, b0); chk("mask_mcnt", mcnt, m0);
    tick();

    // Branch counter saturation
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1); tick();
    end
    idle(); chk("sat_bcnt", bcnt, 15); tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      apply(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
      tick();
    end

    // Reset while waiting for fetch
    idle(); tick();
    apply(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
    apply(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("rwf_state_before", state_o, 1); chk("rwf_pc_src", pc_src_o, 1); chk("rwf_we", pc_we, 0);
    tick();
    idle();
    chk("rwf_state", state_o, 0); chk("rwf_bcnt", bcnt, 0); chk("rwf_mcnt", mcnt, 0);
    chk("rwf_pc_src_after", pc_src_o, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
